// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and helpers for the FIR stream engine
//
// Purpose: FSM state encoding, accumulator width rule and output
// saturation limits shared by fir_stream_engine and fir_coeff_bank.
// Ports: none (package).

package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_HOLD = 2'd2
    } fir_state_e;

    // Wide enough for TAPS full-scale products of opposite-sign extremes.
    function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

    // Saturation limits of a signed out_w-bit result.
    function automatic longint sat_max(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// rtl/fir_coeff_bank.sv - coefficient storage with write qualification
//
// Purpose: holds TAPS signed coefficients; a write lands only when the
// engine opens the write window and the address is in range, otherwise
// it is dropped and coef_err pulses for one cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_open               engine is IDLE with no sample offered
//   coef_we/addr/data     coefficient write request
//   coef                  all coefficients, tap 0 in the low slot
//   coef_err              one-cycle pulse on a rejected write

module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int COEFF_W = 8,
    parameter int TAPS    = 8,
    localparam int AW     = $clog2(TAPS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_open,
    input  logic                         coef_we,
    input  logic [AW-1:0]                coef_addr,
    input  logic [COEFF_W-1:0]           coef_data,
    output logic [TAPS-1:0][COEFF_W-1:0] coef,
    output logic                         coef_err
);

    logic addr_ok;
    logic wr_ok;

    // Non-power-of-two TAPS leaves addresses that map to no coefficient.
    assign addr_ok = ({1'b0, coef_addr} < (AW + 1)'(TAPS));
    assign wr_ok   = coef_we && wr_open && addr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef     <= '0;
            coef_err <= 1'b0;
        end else begin
            coef_err <= coef_we && !wr_ok;
            if (wr_ok) begin
                coef[coef_addr] <= coef_data;
            end
        end
    end

endmodule

// File: rtl/fir_stream_engine.sv
// rtl/fir_stream_engine.sv - time-shared single-multiplier FIR on valid/ready streams
//
// Purpose: each accepted sample shifts into the history, then TAPS
// multiply-accumulate cycles produce one output, shifted and saturated,
// held until the consumer takes it.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      sample stream
//   out_valid/out_ready/out_data   filtered stream
//   coef_we/coef_addr/coef_data    coefficient write port
//   coef_err                       rejected-write pulse
//   sat                            sticky clipping flag
//   busy                           engine not IDLE

module fir_stream_engine
    import fir_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int COEFF_W = 8,
    parameter int TAPS    = 8,
    parameter int OUT_W   = 8,
    parameter int SHIFT   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEFF_W-1:0]       coef_data,
    output logic                     coef_err,
    output logic                     sat,
    output logic                     busy
);

    localparam int     AW     = $clog2(TAPS);
    localparam int     PROD_W = DATA_W + COEFF_W;
    localparam int     ACC_W  = acc_width(DATA_W, COEFF_W, TAPS);
    localparam longint OMAX   = sat_max(OUT_W);
    localparam longint OMIN   = sat_min(OUT_W);

    fir_state_e                  state, state_nxt;
    logic                        ready_q;
    logic [TAPS-1:0][DATA_W-1:0] hist;
    logic [TAPS-1:0][COEFF_W-1:0] coef;
    logic [AW-1:0]               idx;
    logic signed [ACC_W-1:0]     acc;

    logic                        accept;
    logic                        last_tap;
    logic signed [PROD_W-1:0]    x_ext, c_ext, prod;
    logic signed [ACC_W-1:0]     acc_sum, shifted;
    logic signed [63:0]          sh64;
    logic                        clip_hi, clip_lo;
    logic [OUT_W-1:0]            out_nxt;

    fir_coeff_bank #(
        .COEFF_W (COEFF_W),
        .TAPS    (TAPS)
    ) u_coeff_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_open   ((state == ST_IDLE) && !in_valid),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .coef      (coef),
        .coef_err  (coef_err)
    );

    // The one shared multiplier, indexed by the tap counter.
    assign x_ext    = {{COEFF_W{hist[idx][DATA_W-1]}}, hist[idx]};
    assign c_ext    = {{DATA_W{coef[idx][COEFF_W-1]}}, coef[idx]};
    assign prod     = x_ext * c_ext;
    assign acc_sum  = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign shifted  = acc_sum >>> SHIFT;
    assign sh64     = {{(64-ACC_W){shifted[ACC_W-1]}}, shifted};
    assign clip_hi  = (sh64 > OMAX);
    assign clip_lo  = (sh64 < OMIN);
    assign out_nxt  = clip_hi ? OUT_W'(OMAX) : (clip_lo ? OUT_W'(OMIN) : OUT_W'(sh64));
    assign last_tap = (idx == AW'(TAPS - 1));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                // ready_q keeps in_ready low through reset and the release cycle.
                in_ready = ready_q;
                busy     = 1'b0;
                if (in_valid && ready_q) state_nxt = ST_MAC;
            end
            ST_MAC: begin
                if (last_tap) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b0;
            hist     <= '0;
            idx      <= '0;
            acc      <= '0;
            out_data <= '0;
            sat      <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= 1'b1;
            if (accept) begin
                hist <= {hist[TAPS-2:0], in_data};
                idx  <= '0;
                acc  <= '0;
            end
            if (state == ST_MAC) begin
                acc <= acc_sum;
                idx <= idx + AW'(1);
                // The final sum is captured here so out_data is stable for all of HOLD.
                if (last_tap) begin
                    out_data <= out_nxt;
                    if (clip_hi || clip_lo) sat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_stream_engine.sv
// tb/tb_fir_stream_engine.sv - scoreboard bench for fir_stream_engine

module tb_fir_stream_engine;

    localparam int TAPS_A = 4;
    localparam int TAPS_B = 5;

    typedef struct {
        int data;
        int sat;
        int acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_n, b_rst_n;
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_coef_we, a_coef_err, a_sat, a_busy;
    logic [7:0] a_in_data, a_out_data, a_coef_data;
    logic [1:0] a_coef_addr;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_coef_we, b_coef_err, b_sat, b_busy;
    logic [7:0] b_in_data, b_out_data, b_coef_data;
    logic [2:0] b_coef_addr;

    fir_stream_engine #(.DATA_W(8), .COEFF_W(8), .TAPS(TAPS_A), .OUT_W(8), .SHIFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .coef_we(a_coef_we), .coef_addr(a_coef_addr), .coef_data(a_coef_data),
        .coef_err(a_coef_err), .sat(a_sat), .busy(a_busy)
    );

    fir_stream_engine #(.DATA_W(8), .COEFF_W(8), .TAPS(TAPS_B), .OUT_W(8), .SHIFT(7)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
        .coef_err(b_coef_err), .sat(b_sat), .busy(b_busy)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int   ha[$], ca[$], hb[$], cb[$];
    bit   sat_a, sat_b;
    int   a_ready_mode = 1;
    bit   a_prev_valid = 1'b0, a_prev_ready = 1'b0;
    int   a_held = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: dot product of history and coefficients, shift, clip to 8 bits.
    function automatic int fir_ref(input int h[$], input int c[$], input int shift, output bit clip);
        longint s = 0;
        longint v;
        foreach (h[i]) s += longint'(h[i]) * longint'(c[i]);
        v = s >>> shift;
        clip = 1'b0;
        if (v > 127) begin v = 127; clip = 1'b1; end
        else if (v < -128) begin v = -128; clip = 1'b1; end
        return int'(v);
    endfunction

    // out_ready driver: 0 = low, 1 = high, 2 = random.
    initial begin
        a_out_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (a_ready_mode == 2) a_out_ready = 1'($urandom_range(0, 1));
            else a_out_ready = (a_ready_mode == 1);
        end
    end

    // Monitor A: latency, hold stability, backpressure, data and sat.
    initial forever begin
        @(negedge clk);
        if (a_out_valid) begin
            check("a_in_ready_low_in_hold", a_in_ready, 0);
            if (!a_prev_valid) begin
                if (qa.size() == 0) check("a_unexpected_output", 1, 0);
                else check("a_latency", cyc + 1 - qa[0].acc_cyc, TAPS_A + 1);
            end else if (!a_prev_ready) begin
                check("a_hold_stable", $signed(a_out_data), a_held);
            end
            a_held = $signed(a_out_data);
            if (a_out_ready && qa.size() > 0) begin
                ea = qa.pop_front();
                check("a_out_data", $signed(a_out_data), ea.data);
                check("a_sat", a_sat, ea.sat);
            end
        end
        a_prev_valid = a_out_valid;
        a_prev_ready = a_out_ready;
    end

    // Monitor B: out_ready is tied high, so each output lasts one cycle.
    initial forever begin
        @(negedge clk);
        if (b_out_valid) begin
            if (qb.size() == 0) check("b_unexpected_output", 1, 0);
            else begin
                eb = qb.pop_front();
                check("b_latency", cyc + 1 - eb.acc_cyc, TAPS_B + 1);
                check("b_out_data", $signed(b_out_data), eb.data);
                check("b_sat", b_sat, eb.sat);
            end
        end
    end

    task automatic reset_model_a();
        ha = '{0, 0, 0, 0};
        ca = '{0, 0, 0, 0};
        sat_a = 1'b0;
    endtask

    // All driver tasks start and end 1 ns after a rising edge.
    task automatic a_wr(input int addr, input int data, input bit ok);
        a_coef_we = 1'b1; a_coef_addr = 2'(addr); a_coef_data = 8'(data);
        @(posedge clk); #1;
        a_coef_we = 1'b0;
        if (ok) ca[addr] = data;
        @(negedge clk);
        check("a_coef_err_pulse", a_coef_err, int'(!ok));
        @(negedge clk);
        check("a_coef_err_clear", a_coef_err, 0);
        @(posedge clk); #1;
    endtask

    task automatic a_send(input int s, input bit with_we, output int acc_cyc);
        int   n;
        bit   clip;
        exp_t e;
        n = 0;
        acc_cyc = -1;
        a_in_valid = 1'b1;
        a_in_data  = 8'(s);
        if (with_we) begin a_coef_we = 1'b1; a_coef_addr = 2'd1; a_coef_data = 8'd99; end
        @(negedge clk);
        while (!a_in_ready && n < 300) begin @(negedge clk); n++; end
        if (!a_in_ready) check("a_accept_timeout", 0, 1);
        else begin
            acc_cyc = cyc + 1;
            ha.push_front(s);
            void'(ha.pop_back());
            e.data = fir_ref(ha, ca, 0, clip);
            sat_a = sat_a | clip;
            e.sat = int'(sat_a);
            e.acc_cyc = acc_cyc;
            qa.push_back(e);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_coef_we  = 1'b0;
        if (with_we) begin
            @(negedge clk);
            check("a_coef_err_on_accept", a_coef_err, 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic a_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (a_busy && n < 300) begin @(negedge clk); n++; end
        if (a_busy) check("a_idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic b_wr(input int addr, input int data, input bit ok);
        b_coef_we = 1'b1; b_coef_addr = 3'(addr); b_coef_data = 8'(data);
        @(posedge clk); #1;
        b_coef_we = 1'b0;
        if (ok) cb[addr] = data;
        @(negedge clk);
        check("b_coef_err_pulse", b_coef_err, int'(!ok));
        @(posedge clk); #1;
    endtask

    task automatic b_send(input int s);
        int   n;
        bit   clip;
        exp_t e;
        n = 0;
        b_in_valid = 1'b1;
        b_in_data  = 8'(s);
        @(negedge clk);
        while (!b_in_ready && n < 300) begin @(negedge clk); n++; end
        if (!b_in_ready) check("b_accept_timeout", 0, 1);
        else begin
            hb.push_front(s);
            void'(hb.pop_back());
            e.data = fir_ref(hb, cb, 7, clip);
            sat_b = sat_b | clip;
            e.sat = int'(sat_b);
            e.acc_cyc = cyc + 1;
            qb.push_back(e);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    int imp[5] = '{1, 0, 0, 0, 0};
    int ac, ac2, prev, n;

    initial begin
        rst_n = 1'b0; b_rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_coef_we = 1'b0; a_coef_addr = '0; a_coef_data = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_coef_we = 1'b0; b_coef_addr = '0; b_coef_data = '0;
        b_out_ready = 1'b1;
        reset_model_a();
        hb = '{0, 0, 0, 0, 0};
        cb = '{0, 0, 0, 0, 0};
        sat_b = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_sat", a_sat, 0);
        check("rst_a_coef_err", a_coef_err, 0);
        check("rst_b_in_ready", b_in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready_before_edge", a_in_ready, 0);
        @(negedge clk);
        check("release_in_ready_after_edge", a_in_ready, 1);
        @(posedge clk); #1;

        // Impulse response and full-rate throughput
        a_wr(0, 1, 1); a_wr(1, 2, 1); a_wr(2, 3, 1); a_wr(3, 4, 1);
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            a_send(imp[i], 1'b0, ac);
            if (prev >= 0) check("a_throughput", ac - prev, TAPS_A + 2);
            prev = ac;
        end

        // Random coefficients, samples, gaps and out_ready
        a_idle();
        for (int i = 0; i < TAPS_A; i++) a_wr(i, int'($urandom_range(0, 255)) - 128, 1'b1);
        a_ready_mode = 2;
        for (int i = 0; i < 24; i++) begin
            a_send(int'($urandom_range(0, 255)) - 128, 1'b0, ac);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        a_ready_mode = 1;

        // Backpressure: long HOLD, write rejected in HOLD, next accept after handshake
        a_idle();
        a_ready_mode = 0;
        a_send(55, 1'b0, ac);
        fork
            a_send(-7, 1'b0, ac2);
            begin
                repeat (TAPS_A + 1) begin @(posedge clk); #1; end
                a_wr(0, 33, 1'b0);
                repeat (8) begin @(posedge clk); #1; end
                a_ready_mode = 1;
            end
        join
        check("a_bp_accept_after_handshake", ac2 - ac, 18);

        // Saturation, accumulator extremes
        a_idle();
        for (int i = 0; i < TAPS_A; i++) a_wr(i, 127, 1'b1);
        for (int i = 0; i < 4; i++) a_send(127, 1'b0, ac);
        a_idle();
        for (int i = 0; i < TAPS_A; i++) a_wr(i, -128, 1'b1);
        a_send(127, 1'b0, ac);
        for (int i = 0; i < 4; i++) a_send(-128, 1'b0, ac);

        // Coefficient protection: during MAC, with an accept
        a_idle();
        a_wr(0, 1, 1'b1); a_wr(1, 2, 1'b1); a_wr(2, 3, 1'b1); a_wr(3, 4, 1'b1);
        a_send(10, 1'b0, ac);
        a_wr(2, 50, 1'b0);
        a_send(20, 1'b1, ac);
        a_send(-3, 1'b0, ac);
        a_send(0, 1'b0, ac);

        // Reset at MAC cycle 2, then impulse with fresh coefficients
        a_idle();
        a_send(77, 1'b0, ac);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        qa.delete();
        reset_model_a();
        #1;
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_out_data", a_out_data, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_in_ready", a_in_ready, 0);
        check("midrst_sat", a_sat, 0);
        check("midrst_coef_err", a_coef_err, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_release_in_ready_low", a_in_ready, 0);
        @(negedge clk);
        check("midrst_release_in_ready_high", a_in_ready, 1);
        @(posedge clk); #1;
        a_wr(0, -3, 1'b1); a_wr(1, 9, 1'b1); a_wr(2, 2, 1'b1); a_wr(3, 7, 1'b1);
        for (int i = 0; i < 5; i++) a_send(imp[i], 1'b0, ac);

        // Shifted instance: address range, top tap, floor shift
        b_wr(5, 1, 1'b0);
        b_wr(7, 1, 1'b0);
        b_wr(0, 127, 1'b1);
        b_wr(4, -2, 1'b1);
        b_send(127);
        b_send(-128);
        for (int i = 0; i < 3; i++) b_send(0);

        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin @(posedge clk); n++; end
        @(negedge clk);
        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
